exc_commit: RTL and testbench

Writeback-stage exception/commit arbiter of the LoongArch pipeline, sitting directly upstream of the CSR unit. It takes the single instruction in writeback together with the exception flags it collected in IF/ID/EX/MEM. It merges those flags with pending interrupts and decides whether the instruction retires or traps. It then drives one-cycle event pulses (`is_exc`, `is_ertn`, `is_fetch_again`, `is_idle`) with `excode`/`esubcode`/`badvaddr`/`csr_pc` to the CSR unit, flushes the pipeline, and sequences the IDLE wait-for-interrupt state.

---
 rtl/exc_commit_if.sv | 39 +++
 rtl/exc_commit.sv | 195 +++++++++++++++++++
 tb/tb_exc_commit.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/exc_commit_if.sv
// Writeback-to-CSR bundle of the exception/commit arbiter: the writeback
// instruction with its collected flags, interrupt state, and the CSR events.
interface exc_commit_if;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [31:0] wb_vaddr;
    logic [14:0] wb_exc;
    logic        wb_is_ertn;
    logic        wb_is_refetch;
    logic        wb_is_idle;
    logic [11:0] is;
    logic [11:0] lie;
    logic        ie;
    logic        is_exc;
    logic        is_ertn;
    logic        is_fetch_again;
    logic        is_idle;
    logic [5:0]  excode;
    logic [8:0]  esubcode;
    logic [31:0] badvaddr;
    logic [31:0] csr_pc;
    logic        commit;
    logic        flush;
    logic        idle_stall;

    modport master (
        output wb_valid, wb_pc, wb_vaddr, wb_exc, wb_is_ertn, wb_is_refetch,
               wb_is_idle, is, lie, ie,
        input  is_exc, is_ertn, is_fetch_again, is_idle, excode, esubcode,
               badvaddr, csr_pc, commit, flush, idle_stall
    );

    modport slave (
        input  wb_valid, wb_pc, wb_vaddr, wb_exc, wb_is_ertn, wb_is_refetch,
               wb_is_idle, is, lie, ie,
        output is_exc, is_ertn, is_fetch_again, is_idle, excode, esubcode,
               badvaddr, csr_pc, commit, flush, idle_stall
    );
endinterface

// File: rtl/exc_commit.sv
// Writeback exception/commit arbiter: decides retire vs trap, drives registered
// one-cycle CSR event pulses, the pipeline flush and the IDLE wait-for-interrupt.
module exc_commit (
    input  logic        clk,
    input  logic        reset,
    exc_commit_if.slave bus
);
    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_FLUSH     = 2'd1,
        ST_IDLE_WAIT = 2'd2
    } state_t;

    // Flag bit index doubles as priority: lower index is older pipeline stage.
    function automatic logic [3:0] first_exc(input logic [14:0] flags);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 14; i >= 0; i--) begin
            if (flags[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    function automatic logic [5:0] exc_code(input logic [3:0] idx);
        logic [5:0] code;
        case (idx)
            4'd0:    code = 6'h08;
            4'd1:    code = 6'h3F;
            4'd2:    code = 6'h03;
            4'd3:    code = 6'h07;
            4'd4:    code = 6'h0D;
            4'd5:    code = 6'h0E;
            4'd6:    code = 6'h0B;
            4'd7:    code = 6'h0C;
            4'd8:    code = 6'h09;
            4'd9:    code = 6'h08;
            4'd10:   code = 6'h3F;
            4'd11:   code = 6'h01;
            4'd12:   code = 6'h02;
            4'd13:   code = 6'h07;
            4'd14:   code = 6'h04;
            default: code = 6'h00;
        endcase
        return code;
    endfunction

    state_t      state_r, state_next_s;
    logic        is_exc_r, is_ertn_r, is_fetch_again_r, is_idle_r;
    logic [5:0]  excode_r;
    logic [8:0]  esubcode_r;
    logic [31:0] badvaddr_r, csr_pc_r, idle_pc_r;
    logic        flush_r, idle_stall_r;

    logic        is_exc_s, is_ertn_s, is_fetch_again_s, is_idle_s;
    logic [5:0]  excode_s;
    logic [8:0]  esubcode_s;
    logic [31:0] badvaddr_s, csr_pc_s;
    logic        flush_s, idle_stall_s, commit_s, save_idle_s;

    logic        int_pend_s, int_take_s, exc_any_s;
    logic [3:0]  exc_idx_s;

    assign int_pend_s = |(bus.is & bus.lie);
    assign int_take_s = int_pend_s & bus.ie;
    assign exc_any_s  = |bus.wb_exc;
    assign exc_idx_s  = first_exc(bus.wb_exc);

    // Next-state and event decision; flush_r still high means the second flush cycle.
    always_comb begin
        state_next_s     = state_r;
        is_exc_s         = 1'b0;
        is_ertn_s        = 1'b0;
        is_fetch_again_s = 1'b0;
        is_idle_s        = 1'b0;
        excode_s         = 6'h00;
        esubcode_s       = 9'd0;
        badvaddr_s       = 32'd0;
        csr_pc_s         = 32'd0;
        flush_s          = 1'b0;
        idle_stall_s     = 1'b0;
        commit_s         = 1'b0;
        save_idle_s      = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (bus.wb_valid && !flush_r) begin
                    csr_pc_s = bus.wb_pc;
                    if (int_take_s) begin
                        is_exc_s     = 1'b1;
                        flush_s      = 1'b1;
                        state_next_s = ST_FLUSH;
                    end else if (exc_any_s) begin
                        is_exc_s     = 1'b1;
                        excode_s     = exc_code(exc_idx_s);
                        esubcode_s   = (exc_idx_s == 4'd9) ? 9'd1 : 9'd0;
                        if (exc_idx_s <= 4'd3) begin
                            badvaddr_s = bus.wb_pc;
                        end else if (exc_idx_s >= 4'd8) begin
                            badvaddr_s = bus.wb_vaddr;
                        end else begin
                            badvaddr_s = 32'd0;
                        end
                        flush_s      = 1'b1;
                        state_next_s = ST_FLUSH;
                    end else begin
                        commit_s = 1'b1;
                        if (bus.wb_is_ertn) begin
                            is_ertn_s    = 1'b1;
                            flush_s      = 1'b1;
                            state_next_s = ST_FLUSH;
                        end else if (bus.wb_is_refetch) begin
                            is_fetch_again_s = 1'b1;
                            flush_s          = 1'b1;
                            state_next_s     = ST_FLUSH;
                        end else if (bus.wb_is_idle) begin
                            is_idle_s    = 1'b1;
                            flush_s      = 1'b1;
                            idle_stall_s = 1'b1;
                            save_idle_s  = 1'b1;
                            state_next_s = ST_IDLE_WAIT;
                        end else begin
                            csr_pc_s = 32'd0;
                        end
                    end
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                flush_s      = 1'b1;
                state_next_s = ST_RUN;
            end
            ST_IDLE_WAIT: begin
                idle_stall_s = 1'b1;
                if (int_pend_s) begin
                    is_exc_s     = 1'b1;
                    csr_pc_s     = idle_pc_r + 32'd4;
                    flush_s      = 1'b1;
                    state_next_s = ST_FLUSH;
                end else begin
                    state_next_s = ST_IDLE_WAIT;
                end
            end
            default: begin
                state_next_s = ST_RUN;
            end
        endcase
    end

    // State, registered event outputs and the saved IDLE PC.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r          <= ST_RUN;
            is_exc_r         <= 1'b0;
            is_ertn_r        <= 1'b0;
            is_fetch_again_r <= 1'b0;
            is_idle_r        <= 1'b0;
            excode_r         <= 6'h00;
            esubcode_r       <= 9'd0;
            badvaddr_r       <= 32'd0;
            csr_pc_r         <= 32'd0;
            flush_r          <= 1'b0;
            idle_stall_r     <= 1'b0;
            idle_pc_r        <= 32'd0;
        end else begin
            state_r          <= state_next_s;
            is_exc_r         <= is_exc_s;
            is_ertn_r        <= is_ertn_s;
            is_fetch_again_r <= is_fetch_again_s;
            is_idle_r        <= is_idle_s;
            excode_r         <= excode_s;
            esubcode_r       <= esubcode_s;
            badvaddr_r       <= badvaddr_s;
            csr_pc_r         <= csr_pc_s;
            flush_r          <= flush_s;
            idle_stall_r     <= idle_stall_s;
            idle_pc_r        <= save_idle_s ? bus.wb_pc : idle_pc_r;
        end
    end

    assign bus.is_exc         = is_exc_r;
    assign bus.is_ertn        = is_ertn_r;
    assign bus.is_fetch_again = is_fetch_again_r;
    assign bus.is_idle        = is_idle_r;
    assign bus.excode         = excode_r;
    assign bus.esubcode       = esubcode_r;
    assign bus.badvaddr       = badvaddr_r;
    assign bus.csr_pc         = csr_pc_r;
    assign bus.flush          = flush_r;
    assign bus.idle_stall     = idle_stall_r;
    assign bus.commit         = commit_s;
endmodule

// File: tb/tb_exc_commit.sv
// Directed bench for exc_commit: a cycle-level model of the trap/retire rules
// checked every cycle, plus literal expectations on hand-picked vectors.
module tb_exc_commit;
    logic clk;
    logic reset;
    exc_commit_if bus();

    exc_commit dut (.clk(clk), .reset(reset), .bus(bus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Model: excodes by flag bit, and counters for discarded cycles / sleeping.
    int code_tab [0:14] = '{8, 63, 3, 7, 13, 14, 11, 12, 9, 8, 63, 1, 2, 7, 4};
    bit          armed = 1'b0;
    bit          sleeping = 1'b0;
    logic [31:0] sleep_pc = 32'd0;
    int          busy = 0;
    bit          flush2 = 1'b0;
    logic        e_exc = 1'b0, e_ertn = 1'b0, e_fa = 1'b0, e_idle = 1'b0;
    logic        e_flush = 1'b0, e_stall = 1'b0;
    logic [31:0] e_code = 32'd0, e_sub = 32'd0, e_bad = 32'd0, e_pc = 32'd0;

    always @(negedge clk) begin
        logic        n_exc, n_ertn, n_fa, n_idle, n_flush, n_stall;
        logic [31:0] n_code, n_sub, n_bad, n_pc;
        logic        pend, take, open, exp_commit;
        int          first;
        pend  = |(bus.is & bus.lie);
        take  = pend & bus.ie;
        first = -1;
        for (int i = 0; i < 15; i++) begin
            if (bus.wb_exc[i] && first < 0) first = i;
        end
        open = !sleeping && busy == 0;
        exp_commit = bus.wb_valid && open && !take && first < 0;
        if (armed) begin
            chk("is_exc", bus.is_exc, e_exc);
            chk("is_ertn", bus.is_ertn, e_ertn);
            chk("is_fetch_again", bus.is_fetch_again, e_fa);
            chk("is_idle", bus.is_idle, e_idle);
            chk("excode", bus.excode, e_code);
            chk("esubcode", bus.esubcode, e_sub);
            chk("badvaddr", bus.badvaddr, e_bad);
            chk("csr_pc", bus.csr_pc, e_pc);
            chk("flush", bus.flush, e_flush);
            chk("idle_stall", bus.idle_stall, e_stall);
            if (!reset) chk("commit", bus.commit, exp_commit);
        end
        {n_exc, n_ertn, n_fa, n_idle, n_flush, n_stall} = 6'b0;
        {n_code, n_sub, n_bad, n_pc} = 128'd0;
        if (reset) begin
            armed = 1'b1; sleeping = 1'b0; busy = 0; flush2 = 1'b0;
        end else if (sleeping) begin
            n_stall = 1'b1;
            if (pend) begin
                n_exc = 1'b1; n_pc = sleep_pc + 32'd4; n_flush = 1'b1;
                flush2 = 1'b1; busy = 2; sleeping = 1'b0;
            end
        end else if (busy > 0) begin
            busy--;
            n_flush = flush2;
            flush2 = 1'b0;
        end else if (bus.wb_valid) begin
            if (take || first >= 0) begin
                n_exc = 1'b1; n_pc = bus.wb_pc; n_flush = 1'b1; flush2 = 1'b1; busy = 2;
                if (!take) begin
                    n_code = 32'(code_tab[first]);
                    n_sub  = (first == 9) ? 32'd1 : 32'd0;
                    n_bad  = (first < 4) ? bus.wb_pc : (first >= 8) ? bus.wb_vaddr : 32'd0;
                end
            end else if (bus.wb_is_ertn || bus.wb_is_refetch) begin
                n_ertn = bus.wb_is_ertn; n_fa = !bus.wb_is_ertn;
                n_pc = bus.wb_pc; n_flush = 1'b1; flush2 = 1'b1; busy = 2;
            end else if (bus.wb_is_idle) begin
                n_idle = 1'b1; n_pc = bus.wb_pc; n_flush = 1'b1; n_stall = 1'b1;
                sleeping = 1'b1; sleep_pc = bus.wb_pc;
            end
        end
        {e_exc, e_ertn, e_fa, e_idle, e_flush, e_stall} = {n_exc, n_ertn, n_fa, n_idle, n_flush, n_stall};
        {e_code, e_sub, e_bad, e_pc} = {n_code, n_sub, n_bad, n_pc};
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic v, input logic [31:0] pc, input logic [31:0] va,
                         input logic [14:0] ex, input logic er, input logic rf, input logic id);
        bus.wb_valid = v; bus.wb_pc = pc; bus.wb_vaddr = va; bus.wb_exc = ex;
        bus.wb_is_ertn = er; bus.wb_is_refetch = rf; bus.wb_is_idle = id;
        #1;
    endtask

    task automatic nop();
        apply(1'b0, 32'd0, 32'd0, 15'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        bus.is = 12'd0; bus.lie = 12'd0; bus.ie = 1'b0;
        nop();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_flush", bus.flush, 32'd0);
        chk("rst_excode", bus.excode, 32'd0);
        chk("rst_csr_pc", bus.csr_pc, 32'd0);
        chk("rst_stall", bus.idle_stall, 32'd0);

        for (int k = 0; k < 4; k++) begin
            apply(1'b1, 32'h1c000000 + 32'(4 * k), 32'd0, 15'd0, 1'b0, 1'b0, 1'b0);
            chk("plain_commit", bus.commit, 32'd1);
            step();
        end

        apply(1'b1, 32'h1c000100, 32'h00001003, 15'h0900, 1'b0, 1'b0, 1'b0);
        chk("ale_commit_t0", bus.commit, 32'd0);
        step();
        apply(1'b1, 32'h1c000104, 32'd0, 15'd0, 1'b0, 1'b0, 1'b0);
        chk("ale_is_exc", bus.is_exc, 32'd1);
        chk("ale_excode", bus.excode, 32'h09);
        chk("ale_badvaddr", bus.badvaddr, 32'h00001003);
        chk("ale_csr_pc", bus.csr_pc, 32'h1c000100);
        chk("ale_flush_t1", bus.flush, 32'd1);
        chk("ale_commit_t1", bus.commit, 32'd0);
        step();
        apply(1'b1, 32'h1c000108, 32'd0, 15'd0, 1'b0, 1'b0, 1'b0);
        chk("ale_flush_t2", bus.flush, 32'd1);
        chk("ale_commit_t2", bus.commit, 32'd0);
        step();
        apply(1'b1, 32'h1c00010c, 32'd0, 15'd0, 1'b0, 1'b0, 1'b0);
        chk("ale_flush_t3", bus.flush, 32'd0);
        chk("ale_commit_t3", bus.commit, 32'd1);
        step();

        apply(1'b1, 32'h1c000110, 32'h00002222, 15'h0200, 1'b0, 1'b0, 1'b0);
        step(); nop();
        chk("adem_excode", bus.excode, 32'h08);
        chk("adem_esubcode", bus.esubcode, 32'd1);
        chk("adem_badvaddr", bus.badvaddr, 32'h00002222);
        step(); step();

        apply(1'b1, 32'h1c000120, 32'h00003333, 15'h0011, 1'b0, 1'b0, 1'b0);
        step(); nop();
        chk("adef_excode", bus.excode, 32'h08);
        chk("adef_esubcode", bus.esubcode, 32'd0);
        chk("adef_badvaddr", bus.badvaddr, 32'h1c000120);
        step(); step();

        bus.is = 12'h004; bus.lie = 12'h004; bus.ie = 1'b1;
        apply(1'b1, 32'h1c000130, 32'd0, 15'h0040, 1'b0, 1'b0, 1'b0);
        step();
        apply(1'b1, 32'h1c000134, 32'd0, 15'd0, 1'b0, 1'b0, 1'b0);
        chk("int_is_exc", bus.is_exc, 32'd1);
        chk("int_excode", bus.excode, 32'h00);
        chk("int_badvaddr", bus.badvaddr, 32'd0);
        step();
        apply(1'b1, 32'h1c000138, 32'd0, 15'd0, 1'b0, 1'b0, 1'b0);
        step();
        bus.ie = 1'b0;
        apply(1'b1, 32'h1c000140, 32'd0, 15'h0040, 1'b0, 1'b0, 1'b0);
        step(); nop();
        chk("sys_excode", bus.excode, 32'h0B);
        step(); step();
        bus.is = 12'd0; bus.lie = 12'd0;

        apply(1'b1, 32'h1c000150, 32'd0, 15'h0080, 1'b1, 1'b0, 1'b0);
        chk("brk_ertn_commit", bus.commit, 32'd0);
        step(); nop();
        chk("brk_ertn_no_ertn", bus.is_ertn, 32'd0);
        chk("brk_excode", bus.excode, 32'h0C);
        step(); step();

        apply(1'b1, 32'h1c000160, 32'd0, 15'd0, 1'b1, 1'b0, 1'b0);
        chk("ertn_commit", bus.commit, 32'd1);
        step(); nop();
        chk("ertn_pulse", bus.is_ertn, 32'd1);
        chk("ertn_csr_pc", bus.csr_pc, 32'h1c000160);
        step(); step();

        apply(1'b1, 32'h1c000200, 32'd0, 15'd0, 1'b0, 1'b0, 1'b1);
        chk("idle_commit", bus.commit, 32'd1);
        step();
        apply(1'b1, 32'h1c000204, 32'd0, 15'd0, 1'b0, 1'b0, 1'b0);
        chk("idle_pulse", bus.is_idle, 32'd1);
        chk("idle_csr_pc", bus.csr_pc, 32'h1c000200);
        chk("idle_flush", bus.flush, 32'd1);
        chk("idle_stall_t1", bus.idle_stall, 32'd1);
        chk("idle_commit_t1", bus.commit, 32'd0);
        step();
        for (int k = 0; k < 9; k++) begin
            apply(1'b1, 32'h1c000400 + 32'(4 * k), 32'd0, 15'd0, 1'b0, 1'b0, 1'b0);
            step();
        end
        bus.is = 12'h800; bus.lie = 12'h800; bus.ie = 1'b0;
        nop();
        chk("idle_stall_held", bus.idle_stall, 32'd1);
        chk("idle_no_flush", bus.flush, 32'd0);
        step();
        chk("wake_is_exc", bus.is_exc, 32'd1);
        chk("wake_excode", bus.excode, 32'h00);
        chk("wake_csr_pc", bus.csr_pc, 32'h1c000204);
        chk("wake_flush", bus.flush, 32'd1);
        bus.is = 12'd0; bus.lie = 12'd0;
        step();
        chk("wake_stall_drop", bus.idle_stall, 32'd0);
        chk("wake_flush_t2", bus.flush, 32'd1);
        step();

        apply(1'b1, 32'h1c000300, 32'd0, 15'd0, 1'b0, 1'b1, 1'b0);
        chk("refetch_commit", bus.commit, 32'd1);
        step(); nop();
        chk("refetch_pulse", bus.is_fetch_again, 32'd1);
        chk("refetch_csr_pc", bus.csr_pc, 32'h1c000300);
        chk("refetch_flush", bus.flush, 32'd1);
        reset = 1'b1;
        step();
        chk("rst_mid_flush", bus.flush, 32'd0);
        chk("rst_mid_csr_pc", bus.csr_pc, 32'd0);
        reset = 1'b0;
        step();
        apply(1'b1, 32'h1c000310, 32'd0, 15'd0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_commit", bus.commit, 32'd1);
        step(); nop();
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
